// File: rtl/irs_block_lock_arbiter.sv
// irs_block_lock_arbiter
//  Shares the IRS block-manager lock/free port between the event controller,
//  which issues lock pulses, and the readout engine, which issues level free
//  requests. Lock pulses are buffered in a FIFO. Locks win arbitration, but a
//  burst limit of LOCK_BURST consecutive locks guarantees that a pending free
//  is eventually served. The block also keeps a saturating locked-block count
//  and sticky error flags.
//
//  Optional feature, macro LOCK_BITMAP_EN: keeps a 512-entry lock table that
//  flags double locks (err_o[2]) and frees of unlocked blocks (err_o[3]).
//  Without the macro no table is built and err_o[3:2] stay 0.
//
//  LOCK_FIFO_DEPTH must be a power of 2 in 2..32; LOCK_BURST must be >= 1.

module irs_block_lock_arbiter #(
   parameter int unsigned LOCK_FIFO_DEPTH = 8,
   parameter int unsigned LOCK_BURST      = 4
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       lock_req_i,
   input  logic [8:0] lock_block_i,
   input  logic       free_req_i,
   input  logic [8:0] free_block_i,
   output logic       free_ack_o,
   output logic [8:0] mgr_block_o,
   output logic       mgr_lock_o,
   output logic       mgr_free_o,
   input  logic       mgr_ack_i,
   output logic [9:0] locked_count_o,
   input  logic       clr_err_i,
   output logic [3:0] err_o
);

   localparam int unsigned AW         = $clog2(LOCK_FIFO_DEPTH);
   localparam int unsigned BW         = $clog2(LOCK_BURST + 1);
   localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);
   localparam logic [BW-1:0] BURST_MAX = BW'(LOCK_BURST);
   localparam logic [9:0]    COUNT_MAX = 10'd512;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOCK,
      S_FREE
   } state_e;

   state_e        state_q;
   logic [8:0]    mgr_block_q;
   logic          mgr_lock_q;
   logic          mgr_free_q;
   logic          free_ack_q;
   logic [BW-1:0] burst_q;
   logic [9:0]    count_q;
   logic [3:0]    err_q;
   logic [3:0]    err_d;
   logic [3:0]    err_set;

   // Lock FIFO: pointers carry one extra wrap bit to tell full from empty.
   logic [8:0]  fifo_mem_q [LOCK_FIFO_DEPTH];
   logic [AW:0] wr_ptr_q;
   logic [AW:0] rd_ptr_q;
   logic        fifo_empty;
   logic        fifo_full;
   logic        fifo_push;
   logic        fifo_pop;
   logic        fifo_ovf;
   logic [8:0]  fifo_head;

   logic        lock_done;
   logic        free_done;
   logic        free_pend;
   logic        dbl_lock;
   logic        bad_free;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign fifo_head  = fifo_mem_q[rd_ptr_q[AW-1:0]];

   // A completed manager handshake; the acked request is the FIFO head.
   assign lock_done = (state_q == S_LOCK) && mgr_ack_i;
   assign free_done = (state_q == S_FREE) && mgr_ack_i;
   assign fifo_pop  = lock_done;

   // A pop frees a slot in the same cycle, so a push into a full FIFO is
   // only dropped when no lock completes in that cycle.
   assign fifo_push = lock_req_i && (!fifo_full || fifo_pop);
   assign fifo_ovf  = lock_req_i && fifo_full && !fifo_pop;

   // The readout engine still holds free_req_i during the free_ack_o cycle;
   // masking it there keeps one request from being served twice.
   assign free_pend = free_req_i && !free_ack_q;

   // FIFO storage write.
   // NOTE: the data array has no reset; emptiness is defined by the pointers
   // alone, so resetting them is enough and the array stays plain storage.
   always_ff @(posedge clk_i) begin
      if (fifo_push) begin
         fifo_mem_q[wr_ptr_q[AW-1:0]] <= lock_block_i;
      end
   end

   // FIFO pointer update; reset discards every buffered lock.
   // NOTE: sequential state is always assigned with <= so every flop samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (fifo_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (fifo_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   // Arbitration FSM with registered manager outputs, burst limit and count.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= S_IDLE;
         mgr_block_q <= '0;
         mgr_lock_q  <= 1'b0;
         mgr_free_q  <= 1'b0;
         free_ack_q  <= 1'b0;
         burst_q     <= '0;
         count_q     <= '0;
      end else begin
         free_ack_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (!fifo_empty && (!free_pend || (burst_q < BURST_MAX))) begin
                  state_q     <= S_LOCK;
                  mgr_block_q <= fifo_head;
                  mgr_lock_q  <= 1'b1;
               end else if (free_pend) begin
                  state_q     <= S_FREE;
                  mgr_block_q <= free_block_i;
                  mgr_free_q  <= 1'b1;
                  burst_q     <= '0;
               end
            end
            S_LOCK: begin
               if (mgr_ack_i) begin
                  state_q    <= S_IDLE;
                  mgr_lock_q <= 1'b0;
                  if (count_q != COUNT_MAX) count_q <= count_q + 10'd1;
                  if (!free_pend) begin
                     burst_q <= '0;
                  end else if (burst_q != BURST_MAX) begin
                     burst_q <= burst_q + BW'(1);
                  end
               end
            end
            S_FREE: begin
               if (mgr_ack_i) begin
                  state_q    <= S_IDLE;
                  mgr_free_q <= 1'b0;
                  free_ack_q <= 1'b1;
                  if (count_q != 10'd0) count_q <= count_q - 10'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef LOCK_BITMAP_EN
   logic [511:0] lock_map_q;

   // Lock table: set on a completed lock, cleared on a completed free.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         lock_map_q <= '0;
      end else if (lock_done) begin
         lock_map_q[mgr_block_q] <= 1'b1;
      end else if (free_done) begin
         lock_map_q[mgr_block_q] <= 1'b0;
      end
   end

   assign dbl_lock = lock_done && lock_map_q[mgr_block_q];
   assign bad_free = free_done && !lock_map_q[mgr_block_q];
`else
   assign dbl_lock = 1'b0;
   assign bad_free = 1'b0;
`endif

   // Error events of this cycle; a new event overrides a simultaneous clear.
   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      err_set    = '0;
      err_set[0] = fifo_ovf;
      err_set[1] = free_done && (count_q == 10'd0);
      err_set[2] = dbl_lock;
      err_set[3] = bad_free;
      err_d      = (clr_err_i ? 4'b0000 : err_q) | err_set;
   end

   // Sticky error register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         err_q <= '0;
      end else begin
         err_q <= err_d;
      end
   end

   assign free_ack_o     = free_ack_q;
   assign mgr_block_o    = mgr_block_q;
   assign mgr_lock_o     = mgr_lock_q;
   assign mgr_free_o     = mgr_free_q;
   assign locked_count_o = count_q;
   assign err_o          = err_q;

endmodule

// File: tb/tb_irs_block_lock_arbiter.sv
// tb_irs_block_lock_arbiter
//  Scoreboard bench: every lock/free the bench expects the manager port to see
//  is queued as {free, lock, block}; a manager-side responder pops and compares
//  it when the request appears, then acknowledges after a programmable delay.

module tb_irs_block_lock_arbiter;

`ifdef LOCK_BITMAP_EN
   localparam bit BITMAP = 1'b1;
`else
   localparam bit BITMAP = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       lock_req;
   logic [8:0] lock_blk;
   logic       free_req;
   logic [8:0] free_blk;
   logic       free_ack_o;
   logic [8:0] mgr_block;
   logic       mgr_lock;
   logic       mgr_free;
   logic       mgr_ack;
   logic [9:0] count;
   logic       clr_err;
   logic [3:0] err;

   int         checks = 0;
   int         errors = 0;
   logic [10:0] exp_q [$];

   // Responder controls (written by the main sequence only).
   bit         ack_hold = 1'b0;
   int         ack_delay = 0;
   bit         spurious_ack = 1'b0;
   // Responder state.
   int         req_age = 0;
   logic [8:0] req_blk = '0;
   int         free_ack_cnt = 0;

   irs_block_lock_arbiter #(
      .LOCK_FIFO_DEPTH(8),
      .LOCK_BURST     (4)
   ) dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .lock_req_i    (lock_req),
      .lock_block_i  (lock_blk),
      .free_req_i    (free_req),
      .free_block_i  (free_blk),
      .free_ack_o    (free_ack_o),
      .mgr_block_o   (mgr_block),
      .mgr_lock_o    (mgr_lock),
      .mgr_free_o    (mgr_free),
      .mgr_ack_i     (mgr_ack),
      .locked_count_o(count),
      .clr_err_i     (clr_err),
      .err_o         (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [10:0] req_word(input logic is_free, input logic [8:0] blk);
      return {is_free, ~is_free, blk};
   endfunction

   // Manager-side model: compare each new request, ack it, check it drops.
   always @(negedge clk) begin
      if (!rst_n) begin
         mgr_ack = 1'b0;
         req_age = 0;
      end else begin
         if (free_ack_o) free_ack_cnt++;
         if (mgr_ack) begin
            check("req_drop", {30'd0, mgr_lock, mgr_free}, 32'd0);
            mgr_ack = 1'b0;
            req_age = 0;
         end else if (mgr_lock || mgr_free) begin
            if (req_age == 0) begin
               req_blk = mgr_block;
               if (exp_q.size() == 0) begin
                  check("sb_pending", 32'(exp_q.size()), 32'd1);
               end else begin
                  check("sb_req", {21'd0, mgr_free, mgr_lock, mgr_block}, {21'd0, exp_q.pop_front()});
               end
            end
            req_age++;
            if (!ack_hold && req_age > ack_delay) begin
               check("blk_stable", {23'd0, mgr_block}, {23'd0, req_blk});
               mgr_ack = 1'b1;
            end
         end else if (spurious_ack) begin
            mgr_ack = 1'b1;
         end
      end
   end

   task automatic do_reset();
      rst_n    = 1'b0;
      lock_req = 1'b0;
      lock_blk = '0;
      free_req = 1'b0;
      free_blk = '0;
      clr_err  = 1'b0;
      ack_hold = 1'b0;
      ack_delay = 0;
      spurious_ack = 1'b0;
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // One-cycle lock pulse followed by one quiet cycle.
   task automatic lock_pulse(input logic [8:0] blk, input bit expect_issue, input bit with_clr);
      @(posedge clk);
      #1;
      lock_req = 1'b1;
      lock_blk = blk;
      clr_err  = with_clr;
      if (expect_issue) exp_q.push_back(req_word(1'b0, blk));
      @(posedge clk);
      #1;
      lock_req = 1'b0;
      clr_err  = 1'b0;
   endtask

   task automatic raise_free(input logic [8:0] blk);
      @(posedge clk);
      #1;
      free_req = 1'b1;
      free_blk = blk;
   endtask

   // Wait until every expected request has been issued and completed.
   task automatic wait_drain(input int budget);
      int n = 0;
      forever begin
         @(negedge clk);
         if (free_ack_o) free_req = 1'b0;
         if (exp_q.size() == 0 && !mgr_lock && !mgr_free) break;
         n++;
         if (n >= budget) begin
            check("drain_timeout", 32'(exp_q.size()) + {31'd0, mgr_lock | mgr_free}, 32'd0);
            break;
         end
      end
      repeat (3) begin
         @(negedge clk);
         if (free_ack_o) free_req = 1'b0;
      end
   endtask

   initial begin
      int base;

      // ---- Reset state ----
      do_reset();
      @(negedge clk);
      check("rst_lock", {31'd0, mgr_lock}, 32'd0);
      check("rst_free", {31'd0, mgr_free}, 32'd0);
      check("rst_blk", {23'd0, mgr_block}, 32'd0);
      check("rst_count", {22'd0, count}, 32'd0);
      check("rst_err", {28'd0, err}, 32'd0);
      check("rst_fack", {31'd0, free_ack_o}, 32'd0);

      // ---- 1: single lock, ack after 3 cycles, N+2 latency ----
      ack_delay = 3;
      @(posedge clk);
      #1;
      lock_req = 1'b1;
      lock_blk = 9'h005;
      exp_q.push_back(req_word(1'b0, 9'h005));
      @(posedge clk);
      #1 lock_req = 1'b0;
      @(negedge clk);
      check("t1_lock_n1", {31'd0, mgr_lock}, 32'd0);
      @(negedge clk);
      check("t1_lock_n2", {31'd0, mgr_lock}, 32'd1);
      check("t1_blk_n2", {23'd0, mgr_block}, 32'h005);
      wait_drain(50);
      check("t1_count", {22'd0, count}, 32'd1);
      // An ack while idle must be ignored.
      @(posedge clk);
      #1 spurious_ack = 1'b1;
      @(posedge clk);
      #1 spurious_ack = 1'b0;
      repeat (3) @(negedge clk);
      check("t1_spur_count", {22'd0, count}, 32'd1);
      check("t1_spur_req", {30'd0, mgr_lock, mgr_free}, 32'd0);

      // ---- 2: overflow with acks held; 9th pulse drops despite clr ----
      ack_hold  = 1'b1;
      ack_delay = 0;
      for (int i = 0; i < 8; i++) lock_pulse(9'h100 + 9'(i), 1'b1, 1'b0);
      @(negedge clk);
      check("t2_err_before", {28'd0, err}, 32'd0);
      lock_pulse(9'h108, 1'b0, 1'b1);
      @(negedge clk);
      check("t2_ovf_win", {28'd0, err}, 32'h1);
      check("t2_held_blk", {22'd0, mgr_lock, mgr_block}, 32'h300);
      ack_hold = 1'b0;
      wait_drain(200);
      check("t2_count", {22'd0, count}, 32'd9);
      check("t2_err_sticky", {28'd0, err}, 32'h1);
      @(posedge clk);
      #1 clr_err = 1'b1;
      @(posedge clk);
      #1 clr_err = 1'b0;
      @(negedge clk);
      check("t2_err_clr", {28'd0, err}, 32'd0);

      // ---- 3: burst limit: 4 locks, 1 free, 2 locks ----
      base     = free_ack_cnt;
      ack_hold = 1'b1;
      for (int i = 0; i < 6; i++) lock_pulse(9'h020 + 9'(i), i < 4, 1'b0);
      raise_free(9'h1FF);
      exp_q.push_back(req_word(1'b1, 9'h1FF));
      exp_q.push_back(req_word(1'b0, 9'h024));
      exp_q.push_back(req_word(1'b0, 9'h025));
      ack_hold = 1'b0;
      wait_drain(200);
      check("t3_fack_cnt", 32'(free_ack_cnt - base), 32'd1);
      check("t3_count", {22'd0, count}, 32'd14);
      check("t3_err", {28'd0, err}, BITMAP ? 32'h8 : 32'h0);

      // ---- 5: async reset with a lock in flight and 3 buffered ----
      ack_hold = 1'b1;
      lock_pulse(9'h0A0, 1'b1, 1'b0);
      for (int i = 1; i < 4; i++) lock_pulse(9'h0A0 + 9'(i), 1'b0, 1'b0);
      @(negedge clk);
      check("t5_pre_lock", {22'd0, mgr_lock, mgr_block}, 32'h2A0);
      #2 rst_n = 1'b0;
      #1;
      check("t5_async_lock", {31'd0, mgr_lock}, 32'd0);
      check("t5_async_blk", {23'd0, mgr_block}, 32'd0);
      check("t5_async_count", {22'd0, count}, 32'd0);
      check("t5_async_err", {28'd0, err}, 32'd0);
      do_reset();
      repeat (12) @(negedge clk);
      check("t5_no_req", {30'd0, mgr_lock, mgr_free}, 32'd0);
      check("t5_count", {22'd0, count}, 32'd0);

      // ---- 4: free at count 0 ----
      base      = free_ack_cnt;
      ack_delay = 2;
      raise_free(9'h033);
      exp_q.push_back(req_word(1'b1, 9'h033));
      wait_drain(50);
      check("t4_count", {22'd0, count}, 32'd0);
      check("t4_err", {28'd0, err}, BITMAP ? 32'hA : 32'h2);
      check("t4_fack_cnt", 32'(free_ack_cnt - base), 32'd1);

      // ---- 6: double lock and free of an unlocked block ----
      do_reset();
      lock_pulse(9'h010, 1'b1, 1'b0);
      wait_drain(50);
      lock_pulse(9'h010, 1'b1, 1'b0);
      wait_drain(50);
      check("t6_count2", {22'd0, count}, 32'd2);
      raise_free(9'h011);
      exp_q.push_back(req_word(1'b1, 9'h011));
      wait_drain(50);
      check("t6_count1", {22'd0, count}, 32'd1);
      check("t6_err", {28'd0, err}, BITMAP ? 32'hC : 32'h0);

      // ---- 7: count saturation at 512 ----
      do_reset();
      for (int i = 0; i < 513; i++) begin
         lock_pulse(9'(i), 1'b1, 1'b0);
         @(posedge clk);
      end
      wait_drain(200);
      check("t7_sat", {22'd0, count}, 32'd512);
      check("t7_err", {28'd0, err}, BITMAP ? 32'h4 : 32'h0);
      raise_free(9'h0FF);
      exp_q.push_back(req_word(1'b1, 9'h0FF));
      wait_drain(50);
      check("t7_after_free", {22'd0, count}, 32'd511);
      check("t7_err_free", {28'd0, err}, BITMAP ? 32'h4 : 32'h0);
      check("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
